// File: rtl/multi_buffer_event_generator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_buffer_event_generator_if
//  Brief    : SURF command handshake and event-header RAM write port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface multi_buffer_event_generator_if #(
    parameter int BUF_BITS = 2
);
    logic                  cmd_start_o;
    logic [31:0]           cmd_event_id_o;
    logic [BUF_BITS-1:0]   cmd_buffer_o;
    logic                  cmd_busy_i;
    logic                  cmd_done_i;
    logic [BUF_BITS+5:0]   event_addr_o;
    logic [15:0]           event_dat_o;
    logic                  event_wr_o;

    modport master (
        output cmd_start_o, cmd_event_id_o, cmd_buffer_o,
        output event_addr_o, event_dat_o, event_wr_o,
        input  cmd_busy_i, cmd_done_i
    );

    modport slave (
        input  cmd_start_o, cmd_event_id_o, cmd_buffer_o,
        input  event_addr_o, event_dat_o, event_wr_o,
        output cmd_busy_i, cmd_done_i
    );
endinterface
`default_nettype wire

// File: rtl/multi_buffer_event_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_buffer_event_generator
//  Brief    : Queues digitize requests, issues NCMD SURF commands per event and
//             writes the event header. HEADER_CHECKSUM_EN adds an XOR word.
//  Revision : 1.0  initial release
// ============================================================================
module multi_buffer_event_generator #(
    parameter int BUF_BITS    = 2,
    parameter int QDEPTH_BITS = 2,
    parameter int EPOCH_BITS  = 12,
    parameter int NCMD        = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    input  wire logic                      digitize_i,
    input  wire logic [BUF_BITS-1:0]       digitize_buffer_i,
    input  wire logic [3:0]                digitize_source_i,
    input  wire logic [(1<<BUF_BITS)-1:0]  buffer_status_i,
    input  wire logic [31:0]               pattern_i,
    input  wire logic [15:0]               pps_time_i,
    input  wire logic [31:0]               clock_time_i,
    input  wire logic [EPOCH_BITS-1:0]     epoch_i,
    input  wire logic                      evid_reset_i,
    multi_buffer_event_generator_if.master bus,
    output logic                           event_done_o,
    output logic [31:0]                    next_id_o,
    output logic                           overflow_o,
    output logic [QDEPTH_BITS:0]           queue_count_o
);
    localparam int NBUF     = 1 << BUF_BITS;
    localparam int QDEPTH   = 1 << QDEPTH_BITS;
    localparam int LOW_BITS = 32 - EPOCH_BITS;
`ifdef HEADER_CHECKSUM_EN
    localparam int HDR_WORDS = 12;
`else
    localparam int HDR_WORDS = 11;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        CMD       = 3'd2,
        GAP       = 3'd3,
        HDR       = 3'd4,
        DONE      = 3'd5
    } state_t;

    logic                   dig_q, dig_prev_q;
    logic [QDEPTH_BITS-1:0] wptr_q, rptr_q;
    logic [QDEPTH_BITS:0]   count_q;
    logic                   overflow_q;

    logic [BUF_BITS-1:0]    qbuf_q  [QDEPTH];
    logic [3:0]             qsrc_q  [QDEPTH];
    logic [NBUF-1:0]        qstat_q [QDEPTH];
    logic [31:0]            qpat_q  [QDEPTH];
    logic [15:0]            qpps_q  [QDEPTH];
    logic [31:0]            qclk_q  [QDEPTH];

    state_t                 state_q, state_d;
    logic [1:0]             k_q, k_d;
    logic [7:0]             gap_q, gap_d;
    logic [3:0]             widx_q, widx_d;
    logic                   start_q, start_d;
    logic [15:0]            evcnt_q, evcnt_d;
    logic [31:0]            next_id_q;

    logic                   edge_w, full_w, push_w, pop_w;
    logic [BUF_BITS-1:0]    hbuf_w;
    logic [3:0]             hsrc_w;
    logic [NBUF-1:0]        hstat_w;
    logic [31:0]            hpat_w;
    logic [15:0]            hpps_w;
    logic [31:0]            hclk_w;
    logic [7:0]             held_cnt_w;
    logic [15:0]            word0_w;
    logic [5:0]             hdr_addr_w;
    logic [15:0]            hdr_dat_w;

    assign edge_w = dig_q & ~dig_prev_q;
    assign full_w = (count_q == (QDEPTH_BITS+1)'(QDEPTH));
    assign push_w = edge_w & ~full_w;
    assign pop_w  = (state_q == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dig_q      <= 1'b0;
            dig_prev_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dig_q      <= digitize_i;
            dig_prev_q <= dig_q;
            if (push_w) wptr_q <= wptr_q + 1'b1;
            if (pop_w)  rptr_q <= rptr_q + 1'b1;
            if (push_w && !pop_w)
                count_q <= count_q + 1'b1;
            else if (pop_w && !push_w)
                count_q <= count_q - 1'b1;
            if (evid_reset_i)
                overflow_q <= 1'b0;
            else if (edge_w && full_w)
                overflow_q <= 1'b1;
        end
    end

    // Snapshot storage carries no reset: entries are only read while occupied.
    always_ff @(posedge clk_i) begin
        if (push_w) begin
            qbuf_q[wptr_q]  <= digitize_buffer_i;
            qsrc_q[wptr_q]  <= digitize_source_i;
            qstat_q[wptr_q] <= buffer_status_i;
            qpat_q[wptr_q]  <= pattern_i;
            qpps_q[wptr_q]  <= pps_time_i;
            qclk_q[wptr_q]  <= clock_time_i;
        end
    end

    assign hbuf_w  = qbuf_q[rptr_q];
    assign hsrc_w  = qsrc_q[rptr_q];
    assign hstat_w = qstat_q[rptr_q];
    assign hpat_w  = qpat_q[rptr_q];
    assign hpps_w  = qpps_q[rptr_q];
    assign hclk_w  = qclk_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            gap_q   <= 8'd0;
            widx_q  <= 4'd0;
            start_q <= 1'b0;
            evcnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            gap_q   <= gap_d;
            widx_q  <= widx_d;
            start_q <= start_d;
            evcnt_q <= evcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        widx_d  = widx_q;
        start_d = 1'b0;
        evcnt_d = evcnt_q;
        unique case (state_q)
            IDLE: begin
                k_d = 2'd0;
                if (count_q != '0) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!bus.cmd_busy_i) begin
                    start_d = 1'b1;
                    evcnt_d = evcnt_q + 16'd1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.cmd_done_i) begin
                    if (k_q < 2'(NCMD-1)) begin
                        k_d     = k_q + 2'd1;
                        gap_d   = 8'd0;
                        state_d = GAP;
                    end else begin
                        widx_d  = 4'd0;
                        state_d = HDR;
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'(GAP_CYCLES-1)) state_d = WAIT_IDLE;
                else                           gap_d   = gap_q + 8'd1;
            end
            HDR: begin
                if (widx_q == 4'(HDR_WORDS-1)) state_d = DONE;
                else                           widx_d  = widx_q + 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef HEADER_CHECKSUM_EN
    logic [15:0] chk_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                chk_q <= 16'd0;
        else if (state_q != HDR)  chk_q <= 16'd0;
        else                      chk_q <= chk_q ^ hdr_dat_w;
    end
`endif

    always_comb begin
        held_cnt_w = 8'd0;
        for (int i = 0; i < NBUF; i++) begin
            if (hstat_w[i] && (BUF_BITS'(i) != hbuf_w))
                held_cnt_w = held_cnt_w + 8'd1;
        end
        word0_w                 = 16'd0;
        word0_w[15:8]           = held_cnt_w;
        word0_w[4 +: BUF_BITS]  = hbuf_w;
        word0_w[3:0]            = hsrc_w;

        hdr_addr_w = 6'h00;
        hdr_dat_w  = 16'd0;
        case (widx_q)
            4'd0:  begin hdr_addr_w = 6'h10; hdr_dat_w = next_id_q[15:0];  end
            4'd1:  begin hdr_addr_w = 6'h11; hdr_dat_w = next_id_q[31:16]; end
            4'd2:  begin hdr_addr_w = 6'h15; hdr_dat_w = 16'(hstat_w);     end
            4'd3:  begin hdr_addr_w = 6'h01; hdr_dat_w = evcnt_q;          end
            4'd4:  begin hdr_addr_w = 6'h06; hdr_dat_w = hpat_w[15:0];     end
            4'd5:  begin hdr_addr_w = 6'h07; hdr_dat_w = hpat_w[31:16];    end
            4'd6:  begin hdr_addr_w = 6'h04; hdr_dat_w = hpps_w;           end
            4'd7:  begin hdr_addr_w = 6'h12; hdr_dat_w = hclk_w[15:0];     end
            4'd8:  begin hdr_addr_w = 6'h13; hdr_dat_w = hclk_w[31:16];    end
            4'd9:  begin hdr_addr_w = 6'h14; hdr_dat_w = 16'(hbuf_w);      end
            4'd10: begin hdr_addr_w = 6'h00; hdr_dat_w = word0_w;          end
`ifdef HEADER_CHECKSUM_EN
            4'd11: begin hdr_addr_w = 6'h16; hdr_dat_w = chk_q;            end
`endif
            default: ;
        endcase
    end

    // Low counter wraps inside its field; the epoch is always re-sampled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            next_id_q <= 32'd0;
        else if (evid_reset_i)
            next_id_q <= {epoch_i, {LOW_BITS{1'b0}}};
        else if (state_q == DONE)
            next_id_q <= {epoch_i, next_id_q[LOW_BITS-1:0] + LOW_BITS'(1)};
    end

    assign bus.cmd_start_o    = start_q;
    assign bus.cmd_event_id_o = next_id_q;
    assign bus.cmd_buffer_o   = (state_q == IDLE) ? '0 : hbuf_w + BUF_BITS'(k_q);
    assign bus.event_wr_o     = (state_q == HDR);
    assign bus.event_addr_o   = (state_q == HDR) ? {hbuf_w, hdr_addr_w} : '0;
    assign bus.event_dat_o    = (state_q == HDR) ? hdr_dat_w : 16'd0;
    assign event_done_o       = (state_q == DONE);
    assign next_id_o          = next_id_q;
    assign overflow_o         = overflow_q;
    assign queue_count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_buffer_event_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multi_buffer_event_generator
//  Brief    : Directed bench; EPOCH_BITS=30 leaves a 2-bit low counter so the
//             ID wrap is reachable in a handful of events.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_buffer_event_generator;
    localparam int BUF_BITS    = 2;
    localparam int QDEPTH_BITS = 2;
    localparam int EPOCH_BITS  = 30;
    localparam int NCMD        = 2;
    localparam int GAP_CYCLES  = 2;
    localparam int LOW_BITS    = 32 - EPOCH_BITS;
`ifdef HEADER_CHECKSUM_EN
    localparam int HDR_WORDS = 12;
`else
    localparam int HDR_WORDS = 11;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    digitize_i;
    logic [BUF_BITS-1:0]     digitize_buffer_i;
    logic [3:0]              digitize_source_i;
    logic [3:0]              buffer_status_i;
    logic [31:0]             pattern_i;
    logic [15:0]             pps_time_i;
    logic [31:0]             clock_time_i;
    logic [EPOCH_BITS-1:0]   epoch_i;
    logic                    evid_reset_i;
    logic                    event_done_o;
    logic [31:0]             next_id_o;
    logic                    overflow_o;
    logic [QDEPTH_BITS:0]    queue_count_o;

    multi_buffer_event_generator_if #(.BUF_BITS(BUF_BITS)) bus ();

    multi_buffer_event_generator #(
        .BUF_BITS    (BUF_BITS),
        .QDEPTH_BITS (QDEPTH_BITS),
        .EPOCH_BITS  (EPOCH_BITS),
        .NCMD        (NCMD),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .digitize_i        (digitize_i),
        .digitize_buffer_i (digitize_buffer_i),
        .digitize_source_i (digitize_source_i),
        .buffer_status_i   (buffer_status_i),
        .pattern_i         (pattern_i),
        .pps_time_i        (pps_time_i),
        .clock_time_i      (clock_time_i),
        .epoch_i           (epoch_i),
        .evid_reset_i      (evid_reset_i),
        .bus               (bus),
        .event_done_o      (event_done_o),
        .next_id_o         (next_id_o),
        .overflow_o        (overflow_o),
        .queue_count_o     (queue_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  bidx;
        logic [3:0]  src;
        logic [3:0]  status;
        logic [31:0] pattern;
        logic [15:0] pps;
        logic [31:0] clk_t;
        int          busy_cycles;
        logic [1:0]  exp_cmd_buf0;
        logic [1:0]  exp_cmd_buf1;
        logic [15:0] exp_word0;
    } vec_t;

    vec_t        vecs [3];
    vec_t        vw, vo;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_seen = 0;
    int          starts;
    int          d0;
    logic [31:0] exp_id;
    logic [15:0] exp_cnt;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_start"},    32'(bus.cmd_start_o),  32'd0);
        check({tag, "_cmd_event_id"}, bus.cmd_event_id_o,    32'd0);
        check({tag, "_cmd_buffer"},   32'(bus.cmd_buffer_o), 32'd0);
        check({tag, "_event_addr"},   32'(bus.event_addr_o), 32'd0);
        check({tag, "_event_dat"},    32'(bus.event_dat_o),  32'd0);
        check({tag, "_event_wr"},     32'(bus.event_wr_o),   32'd0);
        check({tag, "_event_done"},   32'(event_done_o),     32'd0);
        check({tag, "_next_id"},      next_id_o,             32'd0);
        check({tag, "_overflow"},     32'(overflow_o),       32'd0);
        check({tag, "_queue_count"},  32'(queue_count_o),    32'd0);
    endtask

    function automatic logic [31:0] next_of(input logic [31:0] id);
        logic [LOW_BITS-1:0] lo;
        lo = id[LOW_BITS-1:0] + 1'b1;
        return {epoch_i, lo};
    endfunction

    task automatic push_event(input vec_t v);
        digitize_buffer_i = v.bidx;
        digitize_source_i = v.src;
        buffer_status_i   = v.status;
        pattern_i         = v.pattern;
        pps_time_i        = v.pps;
        clock_time_i      = v.clk_t;
        digitize_i        = 1'b1;
        tick();
        tick();
        digitize_i        = 1'b0;
    endtask

    task automatic serve_event(input vec_t v, input bit evid_at_done, input int abort_word);
        int          t;
        int          nw;
        logic [5:0]  ea [12];
        logic [15:0] ew [12];
        logic [7:0]  ga [12];
        logic [15:0] gd [12];
        logic [31:0] exp_next;
        for (int c = 0; c < NCMD; c++) begin
            t = 0;
            while (bus.cmd_start_o !== 1'b1 && t < 60) begin
                tick();
                t++;
            end
            if (t >= 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cmd_start_timeout: no start after %0d cycles, required one", t);
                return;
            end
            if (c > 0) check("cmd_gap_ge_min", 32'(t >= GAP_CYCLES), 32'd1);
            check($sformatf("cmd_buffer[%0d]", c), 32'(bus.cmd_buffer_o),
                  32'(c == 0 ? v.exp_cmd_buf0 : v.exp_cmd_buf1));
            check("cmd_event_id", bus.cmd_event_id_o, exp_id);
            tick();
            check("cmd_start_one_cycle", 32'(bus.cmd_start_o), 32'd0);
            tick();
            bus.cmd_done_i = 1'b1;
            tick();
            bus.cmd_done_i = 1'b0;
        end
        exp_cnt = exp_cnt + 16'(NCMD);

        ea[0]  = 6'h10; ew[0]  = exp_id[15:0];
        ea[1]  = 6'h11; ew[1]  = exp_id[31:16];
        ea[2]  = 6'h15; ew[2]  = 16'(v.status);
        ea[3]  = 6'h01; ew[3]  = exp_cnt;
        ea[4]  = 6'h06; ew[4]  = v.pattern[15:0];
        ea[5]  = 6'h07; ew[5]  = v.pattern[31:16];
        ea[6]  = 6'h04; ew[6]  = v.pps;
        ea[7]  = 6'h12; ew[7]  = v.clk_t[15:0];
        ea[8]  = 6'h13; ew[8]  = v.clk_t[31:16];
        ea[9]  = 6'h14; ew[9]  = 16'(v.bidx);
        ea[10] = 6'h00; ew[10] = v.exp_word0;
        ea[11] = 6'h16; ew[11] = 16'd0;
        for (int i = 0; i < 11; i++) ew[11] = ew[11] ^ ew[i];

        nw = 0;
        t  = 0;
        while (event_done_o !== 1'b1 && t < 40) begin
            if (bus.event_wr_o === 1'b1) begin
                if (nw < 12) begin
                    ga[nw] = bus.event_addr_o;
                    gd[nw] = bus.event_dat_o;
                end
                if (nw == abort_word) begin
                    #2 rst_i = 1'b1;
                    #1 check_all_zero("async_rst");
                    return;
                end
                nw++;
            end
            tick();
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL event_done_timeout: no done after %0d cycles, required one", t);
            return;
        end
        done_seen++;
        check("hdr_word_count", 32'(nw), 32'(HDR_WORDS));
        for (int i = 0; i < HDR_WORDS && i < nw; i++) begin
            check($sformatf("hdr_addr[%0d]", i), 32'(ga[i]), 32'({v.bidx, ea[i]}));
            check($sformatf("hdr_dat[%0d]", i),  32'(gd[i]), 32'(ew[i]));
        end

        exp_next = evid_at_done ? {epoch_i, {LOW_BITS{1'b0}}} : next_of(exp_id);
        if (evid_at_done) evid_reset_i = 1'b1;
        tick();
        evid_reset_i = 1'b0;
        check("event_done_one_cycle", 32'(event_done_o), 32'd0);
        check("next_id_after_done", next_id_o, exp_next);
        exp_id = exp_next;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_i             = 1'b1;
        digitize_i        = 1'b0;
        digitize_buffer_i = '0;
        digitize_source_i = '0;
        buffer_status_i   = '0;
        pattern_i         = '0;
        pps_time_i        = '0;
        clock_time_i      = '0;
        epoch_i           = '0;
        evid_reset_i      = 1'b0;
        bus.cmd_busy_i    = 1'b0;
        bus.cmd_done_i    = 1'b0;
        exp_id            = 32'd0;
        exp_cnt           = 16'd0;

        //            bidx   src    status   pattern        pps       clock          busy buf0   buf1   word0
        vecs[0] = '{2'd2, 4'h5, 4'b0110, 32'hDEADBEEF, 16'h1234, 32'hCAFEF00D, 0,  2'd2, 2'd3, 16'h0125};
        vecs[1] = '{2'd3, 4'hA, 4'b1111, 32'h01234567, 16'h0001, 32'h00010002, 0,  2'd3, 2'd0, 16'h033A};
        vecs[2] = '{2'd0, 4'hF, 4'b0000, 32'hFFFF0000, 16'hFFFF, 32'hFFFFFFFF, 10, 2'd0, 2'd1, 16'h000F};
        vw      = '{2'd1, 4'h3, 4'b0010, 32'h0F0F0F0F, 16'h0042, 32'h12345678, 0,  2'd1, 2'd2, 16'h0013};
        vo      = '{2'd1, 4'h2, 4'b1011, 32'hA5A5_5A5A, 16'h0777, 32'h0BADCAFE, 0,  2'd1, 2'd2, 16'h0212};

        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            bus.cmd_busy_i = (vecs[i].busy_cycles > 0);
            push_event(vecs[i]);
            check("queue_count_after_push", 32'(queue_count_o), 32'd1);
            if (vecs[i].busy_cycles > 0) begin
                starts = 0;
                for (int b = 0; b < vecs[i].busy_cycles; b++) begin
                    tick();
                    if (bus.cmd_start_o === 1'b1) starts++;
                end
                check("bp_no_start_while_busy", 32'(starts), 32'd0);
                bus.cmd_busy_i = 1'b0;
                tick();
                check("bp_start_after_busy_drop", 32'(bus.cmd_start_o), 32'd1);
            end
            serve_event(vecs[i], 1'b0, -1);
        end

        // Low counter sits at 3: the next DONE wraps it without touching the epoch.
        epoch_i = 30'hABC;
        push_event(vw);
        serve_event(vw, 1'b0, -1);
        check("id_wrap_value", next_id_o, 32'h0000_2AF0);

        push_event(vw);
        serve_event(vw, 1'b1, -1);
        check("evid_reset_beats_increment", next_id_o, 32'h0000_2AF0);

        bus.cmd_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_event(vo);
            tick();
            tick();
        end
        check("ovf_queue_count", 32'(queue_count_o), 32'd4);
        check("ovf_flag_set", 32'(overflow_o), 32'd1);
        bus.cmd_busy_i = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 4; i++) serve_event(vo, 1'b0, -1);
        check("ovf_events_completed", 32'(done_seen - d0), 32'd4);
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.cmd_start_o === 1'b1) starts++;
        end
        check("ovf_fifth_entry_lost", 32'(starts), 32'd0);
        check("ovf_queue_drained", 32'(queue_count_o), 32'd0);
        check("ovf_flag_sticky", 32'(overflow_o), 32'd1);
        evid_reset_i = 1'b1;
        tick();
        evid_reset_i = 1'b0;
        check("ovf_cleared_by_evid_reset", 32'(overflow_o), 32'd0);
        exp_id = {epoch_i, {LOW_BITS{1'b0}}};

        push_event(vecs[0]);
        serve_event(vecs[0], 1'b0, 5);
        tick();
        rst_i = 1'b0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.event_wr_o === 1'b1 || bus.cmd_start_o === 1'b1) starts++;
        end
        check("no_activity_after_abort", 32'(starts), 32'd0);
        exp_id  = 32'd0;
        exp_cnt = 16'd0;
        push_event(vecs[0]);
        serve_event(vecs[0], 1'b0, -1);
        check("fresh_event_next_id", next_id_o, 32'h0000_2AF1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multi_buffer_event_generator.md
Name: multi_buffer_event_generator

Overview:
- Parametrised successor to the dual-command event generator. Serves NBUF digitizer buffers, a configurable number of SURF command repeats per event, and a multi-entry trigger queue, all on one clock.
- On each digitize request it snapshots the trigger context into a queue. For each queued event it sequences the SURF command handshake(s), then writes the event header words into the event RAM of the selected buffer.
- Sits between the trigger/hold logic and the SURF command interface / event header RAM.

Parameters:
- BUF_BITS, 2, log2 of buffer count; NBUF = 2**BUF_BITS.
- QDEPTH_BITS, 2, log2 of trigger queue depth; depth = 2**QDEPTH_BITS.
- EPOCH_BITS, 12, width of the epoch field in the event ID; the low counter is 32-EPOCH_BITS bits.
- NCMD, 2, SURF command issues per event (1..4).
- GAP_CYCLES, 2, idle cycles between successive commands of one event (>=1).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- digitize_i  in  1  digitize request level; rising edge starts a capture.
- digitize_buffer_i  in  BUF_BITS  buffer being digitized.
- digitize_source_i  in  4  trigger source code.
- buffer_status_i  in  NBUF  held-buffer bitmap.
- pattern_i  in  32  trigger pattern.
- pps_time_i  in  16  PPS counter.
- clock_time_i  in  32  clock counter.
- epoch_i  in  EPOCH_BITS  run epoch.
- evid_reset_i  in  1  event ID reset.
- cmd_start_o  out  1  one-cycle command start pulse.
- cmd_event_id_o  out  32  event ID for the command.
- cmd_buffer_o  out  BUF_BITS  buffer for the command.
- cmd_busy_i  in  1  command interface busy.
- cmd_done_i  in  1  command complete pulse.
- event_addr_o  out  BUF_BITS+6  {buffer, word address}.
- event_dat_o  out  16  header word.
- event_wr_o  out  1  header write strobe.
- event_done_o  out  1  one-cycle event-complete pulse.
- next_id_o  out  32  current event ID.
- overflow_o  out  1  sticky queue-overflow flag.
- queue_count_o  out  QDEPTH_BITS+1  queue occupancy.

Behaviour:
- Clocking/reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: all outputs 0; queue empty; FSM in IDLE; next_id = 0; event count = 0.
- Reset mid-event: aborts immediately; a partially written header is not completed.
- Capture:
  - digitize_i is registered, and the rising edge is detected one cycle later.
  - On the detected edge, all inputs are snapshotted as one queue entry (single write) and queue_count increments on the next edge.
  - If the queue is full, the entry is dropped and overflow_o sets. overflow_o clears only on evid_reset_i or reset.
  - Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, WAIT_IDLE, CMD, GAP, HDR, DONE.
  - IDLE: queue non-empty -> WAIT_IDLE; command index k = 0.
  - WAIT_IDLE: on !cmd_busy_i, pulse cmd_start_o for one cycle -> CMD. Event count += 1 on each start.
  - CMD: wait for cmd_done_i. Then, if k < NCMD-1: k++ -> GAP; otherwise -> HDR.
  - GAP: hold GAP_CYCLES cycles -> WAIT_IDLE.
  - HDR: write one word per cycle (event_wr_o high); after the last word -> DONE.
  - DONE: pulse event_done_o, pop the queue, increment the event ID -> IDLE.
- Command outputs:
  - cmd_buffer_o = (entry buffer + k) mod NBUF.
  - cmd_event_id_o = next_id_o, stable from the start pulse until DONE.
- Header sequence (word address: content), upper address bits = entry buffer:
  - 0x10: id[15:0]
  - 0x11: id[31:16]
  - 0x15: status zero-extended
  - 0x01: event count[15:0] after this event's commands
  - 0x06: pattern[15:0]
  - 0x07: pattern[31:16]
  - 0x04: pps
  - 0x12: clock[15:0]
  - 0x13: clock[31:16]
  - 0x14: buffer index
  - 0x00: {popcount of held buffers excluding own (8b), zero pad, buffer index, source[3:0]}
- Event ID update:
  - In DONE: next_id = {epoch_i, low+1}. The low field wraps to 0 within its width; no carry into the epoch.
  - evid_reset_i loads {epoch_i, 0} and wins over a simultaneous increment.

Optional Feature:
- Macro: HEADER_CHECKSUM_EN.
- Defined: after word 0x00, one extra write to 0x16 carrying the XOR of all preceding header words of that event. Header is 12 words; event_done_o comes one cycle later.
- Undefined: 11 words only; address 0x16 is never written.

Test Plan:
- Single event, BUF_BITS=2, NCMD=2, buffer 2, source 0x5, pattern 0xDEADBEEF:
  - two cmd_start_o pulses with cmd_buffer_o 2 then 3, gap >= 2 cycles;
  - 11 writes with event_addr_o upper bits = 2; 0x06=0xBEEF, 0x07=0xDEAD, 0x01=0x0002;
  - event_done_o once; next_id_o 0 -> 1.
- Backpressure: hold cmd_busy_i high 10 cycles with an event queued -> no cmd_start_o until busy drops; start follows one cycle after.
- Queue overflow, QDEPTH_BITS=2: 5 edges while cmd_done_i withheld -> queue_count_o=4, overflow_o=1; the fifth entry is lost and only 4 events complete.
- ID wrap and reset: epoch 0xABC, low=0xFFFFF, one event -> next_id_o=0xABC00000. evid_reset_i asserted in the same cycle as DONE -> {epoch_i, 0}.
- Async reset asserted during HDR at word 5 -> all outputs 0 immediately; no further writes; a later event starts fresh with next_id 0.
- With HEADER_CHECKSUM_EN defined: word 0x16 equals the XOR of the 11 prior words; event_done_o is 12 cycles after HDR entry.
